// File: rtl/sb_unpack_ctrl.sv
// rtl/sb_unpack_ctrl.sv - sequencer for the synapse-buffer unpacker datapath
//
// Fetches packed words into the unpacker's two-row register and, each cycle
// that enough bits are resident, presents one P-bit weight. The shift and mask
// are valid in the same cycle the unpacker register holds the data.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_start       start pulse (sampled in IDLE only)
//   i_prec        weight precision P (0 or >16 means 16), latched at start
//   i_count       number of weights, latched at start
//   o_rd_req      one-cycle read request for the next packed word
//   i_rd_valid    read data valid this cycle on the unpacker input
//   o_load        row-load strobe (01 = row0, 10 = row1), same cycle as i_rd_valid
//   o_s           rotate amount (bit pointer) to the unpacker
//   o_z           zero-extension mask, low P bits set
//   o_out_valid   unpacker output holds a valid weight this cycle
//   o_busy        high from the cycle after start until done
//   o_done        one-cycle pulse after the last weight

module sb_unpack_ctrl #(
    parameter int BIT_WIDTH  = 16,
    parameter int SHIFT_BITS = 5,
    parameter int CNT_BITS   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [4:0]            i_prec,
    input  logic [CNT_BITS-1:0]   i_count,
    output logic                  o_rd_req,
    input  logic                  i_rd_valid,
    output logic [1:0]            o_load,
    output logic [SHIFT_BITS-1:0] o_s,
    output logic [BIT_WIDTH-1:0]  o_z,
    output logic                  o_out_valid,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int LG     = $clog2(BIT_WIDTH);
    localparam int PROD_W = CNT_BITS + LG;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state;
    logic [4:0]            prec;
    logic [SHIFT_BITS-1:0] ptr;
    logic [1:0]            full;
    logic [CNT_BITS-1:0]   cnt_left;
    logic [CNT_BITS-1:0]   words_total;
    logic [CNT_BITS-1:0]   words_req;
    logic                  outstanding;
    logic                  pend_row;
    logic                  next_row;
    logic [SHIFT_BITS-1:0] s_last;
    logic [BIT_WIDTH-1:0]  z_last;

    logic [4:0]            prec_eff;
    logic [PROD_W-1:0]     prod;
    logic [PROD_W-1:0]     prod_rnd;
    logic [CNT_BITS-1:0]   start_words;
    logic                  cur_row;
    logic [SHIFT_BITS-1:0] span_sum;
    logic                  spans;
    logic                  emit;
    logic [SHIFT_BITS-1:0] ptr_next;
    logic [1:0]            vac_mask;
    logic                  load_fire;
    logic [1:0]            load_mask;
    logic [1:0]            full_after;
    logic                  req_ok;
    logic [BIT_WIDTH-1:0]  zmask;

    always_comb begin
        prec_eff = ((i_prec == 5'd0) || (i_prec > 5'(BIT_WIDTH))) ? 5'(BIT_WIDTH) : i_prec;
        prod     = PROD_W'(i_count) * PROD_W'(prec_eff);
        prod_rnd = prod + PROD_W'(BIT_WIDTH - 1);
        start_words = CNT_BITS'(prod_rnd >> LG);
    end

    always_comb begin
        zmask = '0;
        for (int i = 0; i < BIT_WIDTH; i++) begin
            zmask[i] = (i < int'(prec));
        end
    end

    always_comb begin
        cur_row  = ptr[SHIFT_BITS-1];
        // Offset within the current row plus P; beyond one row means the
        // weight also reaches into the other row.
        span_sum = {1'b0, ptr[SHIFT_BITS-2:0]} + SHIFT_BITS'(prec);
        spans    = (span_sum > SHIFT_BITS'(BIT_WIDTH));
        emit     = !rst && (state == RUN) && full[cur_row] && (!spans || full[~cur_row]);
        ptr_next = ptr + SHIFT_BITS'(prec);

        vac_mask = 2'b00;
        if (emit && (ptr_next[SHIFT_BITS-1] != cur_row)) begin
            vac_mask = cur_row ? 2'b10 : 2'b01;
        end

        load_fire = !rst && i_rd_valid && outstanding;
        load_mask = 2'b00;
        if (load_fire) begin
            load_mask = pend_row ? 2'b10 : 2'b01;
        end

        // Look ahead: a read completing or a row being vacated this cycle
        // frees the fetch path now, which keeps P <= 8 streaming bubble-free.
        full_after = full & ~vac_mask;
        req_ok     = (state == RUN) && (!outstanding || load_fire) &&
                     (words_req < words_total) && !full_after[next_row];
    end

    assign o_load      = load_mask;
    assign o_out_valid = emit;
    assign o_s         = rst ? '0 : (emit ? ptr : s_last);
    assign o_z         = rst ? '0 : (emit ? zmask : z_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            prec        <= 5'd0;
            ptr         <= '0;
            full        <= 2'b00;
            cnt_left    <= '0;
            words_total <= '0;
            words_req   <= '0;
            outstanding <= 1'b0;
            pend_row    <= 1'b0;
            next_row    <= 1'b0;
            s_last      <= '0;
            z_last      <= '0;
            o_rd_req    <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_rd_req <= 1'b0;
            o_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        prec        <= prec_eff;
                        cnt_left    <= i_count;
                        words_total <= start_words;
                        words_req   <= '0;
                        ptr         <= '0;
                        full        <= 2'b00;
                        outstanding <= 1'b0;
                        next_row    <= 1'b0;
                        if (i_count == '0) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            state  <= RUN;
                            o_busy <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    full <= (full | load_mask) & ~vac_mask;
                    if (load_fire) begin
                        outstanding <= 1'b0;
                    end
                    if (req_ok) begin
                        o_rd_req    <= 1'b1;
                        outstanding <= 1'b1;
                        pend_row    <= next_row;
                        next_row    <= ~next_row;
                        words_req   <= words_req + 1'b1;
                    end
                    if (emit) begin
                        ptr      <= ptr_next;
                        cnt_left <= cnt_left - 1'b1;
                        s_last   <= ptr;
                        z_last   <= zmask;
                        if (cnt_left == CNT_BITS'(1)) begin
                            state  <= DONE;
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A row is only re-requested once it is empty, so it can never be
    // loaded and vacated in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ((load_mask & vac_mask) == 2'b00);
        end
    end

endmodule

// File: tb/tb_sb_unpack_ctrl.sv
// tb/tb_sb_unpack_ctrl.sv - self-checking bench for sb_unpack_ctrl
module tb_sb_unpack_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic [4:0]  i_prec;
    logic [15:0] i_count;
    logic        o_rd_req;
    logic        i_rd_valid;
    logic [1:0]  o_load;
    logic [4:0]  o_s;
    logic [15:0] o_z;
    logic        o_out_valid;
    logic        o_busy;
    logic        o_done;

    int checks = 0;
    int errors = 0;

    logic [31:0]   r_model;
    logic [15:0]   rd_data;
    logic [1023:0] stream;

    always #5 clk = ~clk;

    sb_unpack_ctrl #(.BIT_WIDTH(16), .SHIFT_BITS(5), .CNT_BITS(16)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_prec(i_prec), .i_count(i_count),
        .o_rd_req(o_rd_req), .i_rd_valid(i_rd_valid), .o_load(o_load), .o_s(o_s),
        .o_z(o_z), .o_out_valid(o_out_valid), .o_busy(o_busy), .o_done(o_done)
    );

    typedef struct {
        int prec_in;
        int count;
        int lat;
        int exp_p;
        int exp_words;
        bit restart;
        bit no_bubble;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mask16(input int p);
        logic [16:0] m;
        m = (17'd1 << p) - 17'd1;
        return m[15:0];
    endfunction

    function automatic logic [15:0] wgt(input int k, input int p);
        logic [31:0] t;
        t = k * 40503 + p * 97 + 11;
        return t[15:0] & mask16(p);
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] r, input int s);
        return (r >> s) | (r << (32 - s));
    endfunction

    task automatic do_run(input vec_t v);
        int word_idx, pend_at, n_req, n_load, n_valid, n_done;
        int first_rv, first_ov, last_ov, done_cyc, bubble, overlap, k;
        bit pending, stop;
        logic [4:0]  last_s;
        logic [15:0] w;
        logic [31:0] rot;

        stream = '0;
        for (int i = 0; i < v.count; i++) begin
            w = wgt(i, v.exp_p);
            for (int b = 0; b < v.exp_p; b++) stream[i * v.exp_p + b] = w[b];
        end
        word_idx = 0; pend_at = 0; pending = 0; n_req = 0; n_load = 0;
        n_valid = 0; n_done = 0; first_rv = -1; first_ov = -1; last_ov = -1;
        done_cyc = -1; bubble = 0; overlap = 0; stop = 0; last_s = 0;

        for (int c = 0; c < 400 && !stop; c++) begin
            @(posedge clk);
            #1;
            i_start = 1'b0;
            if (c == 0) begin
                i_start = 1'b1;
                i_prec  = 5'(v.prec_in);
                i_count = 16'(v.count);
            end else if (v.restart && c == 6) begin
                i_start = 1'b1;
                i_prec  = 5'd9;
                i_count = 16'd1;
            end
            i_rd_valid = pending && (c == pend_at);
            rd_data    = stream[word_idx * 16 +: 16];
            #1;
            if (o_out_valid) begin
                k   = n_valid;
                rot = rotr(r_model, int'(o_s));
                check("o_s", 32'(o_s), 32'((k * v.exp_p) % 32));
                check("o_z", 32'(o_z), 32'(mask16(v.exp_p)));
                check("weight", 32'(rot[15:0] & o_z), 32'(wgt(k, v.exp_p)));
                if (last_ov >= 0 && c != last_ov + 1) bubble++;
                if (first_ov < 0) first_ov = c;
                last_ov = c;
                last_s  = o_s;
                n_valid++;
            end
            if (i_rd_valid) begin
                check("o_load", 32'(o_load), (word_idx % 2) ? 32'd2 : 32'd1);
                if (o_load == 2'b01) r_model[15:0]  = rd_data;
                if (o_load == 2'b10) r_model[31:16] = rd_data;
                if (first_rv < 0) first_rv = c;
                word_idx++;
                pending = 0;
                n_load++;
            end
            if (o_rd_req) begin
                if (pending) overlap++;
                pending = 1;
                pend_at = c + v.lat;
                n_req++;
            end
            if (o_done) begin
                n_done++;
                done_cyc = c;
                check("busy_at_done", 32'(o_busy), 32'd0);
            end
            if (done_cyc >= 0 && c >= done_cyc + 2) stop = 1;
        end

        i_start = 1'b0;
        i_rd_valid = 1'b0;
        check("n_req", n_req, v.exp_words);
        check("n_load", n_load, v.exp_words);
        check("n_valid", n_valid, v.count);
        check("n_done", n_done, 1);
        check("overlap", overlap, 0);
        check("busy_after", 32'(o_busy), 32'd0);
        if (v.count == 0) begin
            check("done_cycle", done_cyc, 1);
        end else begin
            check("done_after_last", done_cyc, last_ov + 1);
            check("first_after_load", 32'(first_ov > first_rv), 32'd1);
            check("s_hold", 32'(o_s), 32'(last_s));
            check("z_hold", 32'(o_z), 32'(mask16(v.exp_p)));
        end
        if (v.no_bubble) check("no_bubble", bubble, 0);
    endtask

    initial begin
        bit seen;
        int pend_at, late_req;

        vecs[0] = '{prec_in: 16, count: 3,  lat: 1, exp_p: 16, exp_words: 3, restart: 0, no_bubble: 0};
        vecs[1] = '{prec_in: 5,  count: 7,  lat: 1, exp_p: 5,  exp_words: 3, restart: 0, no_bubble: 0};
        vecs[2] = '{prec_in: 8,  count: 0,  lat: 1, exp_p: 8,  exp_words: 0, restart: 0, no_bubble: 0};
        vecs[3] = '{prec_in: 3,  count: 20, lat: 4, exp_p: 3,  exp_words: 4, restart: 0, no_bubble: 0};
        vecs[4] = '{prec_in: 0,  count: 3,  lat: 2, exp_p: 16, exp_words: 3, restart: 0, no_bubble: 0};
        vecs[5] = '{prec_in: 20, count: 3,  lat: 1, exp_p: 16, exp_words: 3, restart: 0, no_bubble: 0};
        vecs[6] = '{prec_in: 8,  count: 8,  lat: 1, exp_p: 8,  exp_words: 4, restart: 0, no_bubble: 1};
        vecs[7] = '{prec_in: 4,  count: 10, lat: 2, exp_p: 4,  exp_words: 3, restart: 1, no_bubble: 0};
        vecs[8] = '{prec_in: 7,  count: 5,  lat: 3, exp_p: 7,  exp_words: 3, restart: 0, no_bubble: 0};
        vecs[9] = '{prec_in: 1,  count: 17, lat: 1, exp_p: 1,  exp_words: 2, restart: 0, no_bubble: 0};

        rst = 1'b1; i_start = 1'b0; i_prec = '0; i_count = '0; i_rd_valid = 1'b0;
        rd_data = '0; r_model = '0; stream = '0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_rd_req", 32'(o_rd_req), 0);
        check("rst_load", 32'(o_load), 0);
        check("rst_s", 32'(o_s), 0);
        check("rst_z", 32'(o_z), 0);
        check("rst_valid", 32'(o_out_valid), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_done", 32'(o_done), 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) do_run(vecs[i]);

        // Abort with a read outstanding, then a late read response.
        seen = 0; pend_at = 0; late_req = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk);
            #1;
            i_start = (c == 0); i_prec = 5'd5; i_count = 16'd7;
            #1;
            if (o_rd_req) begin
                seen = 1;
                pend_at = c + 6;
            end
        end
        check("abort_req_seen", 32'(seen), 1);
        i_start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort_busy", 32'(o_busy), 0);
        check("abort_s", 32'(o_s), 0);
        check("abort_z", 32'(o_z), 0);
        check("abort_done", 32'(o_done), 0);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            i_rd_valid = (c == 2);
            rd_data = 16'hA5A5;
            #1;
            if (o_rd_req) late_req++;
            if (i_rd_valid) begin
                check("late_load", 32'(o_load), 0);
                check("late_valid", 32'(o_out_valid), 0);
            end
        end
        i_rd_valid = 1'b0;
        check("late_no_req", late_req, 0);
        check("late_idle", 32'(o_busy), 0);
        do_run('{prec_in: 8, count: 2, lat: 1, exp_p: 8, exp_words: 1, restart: 0, no_bubble: 0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
